// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: optional synchroniser, stability filter and per-channel
// rising/falling/both edge qualification with sticky event flags.
module multi_edge_detector #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [CHANNELS-1:0]   data,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clear,
    output logic [CHANNELS-1:0]   edge_detect,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   sticky,
    output logic                  any_event
);

    localparam int unsigned CntW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES - 1);

    logic [CHANNELS-1:0] syn;

    if (SYNC_STAGES == 0) begin : g_no_sync
        assign syn = data;
    end else begin : g_sync
        logic [CHANNELS-1:0] chain_q [SYNC_STAGES];

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                    chain_q[s] <= '0;
                end
            end else begin
                chain_q[0] <= data;
                for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                    chain_q[s] <= chain_q[s-1];
                end
            end
        end

        assign syn = chain_q[SYNC_STAGES-1];
    end

    logic [CntW-1:0]     cnt_q [CHANNELS];
    logic [CntW-1:0]     cnt_d [CHANNELS];
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] edge_q, edge_d;
    logic [CHANNELS-1:0] sticky_q, sticky_d;

    always_comb begin
        cnt_d    = cnt_q;
        level_d  = level_q;
        edge_d   = '0;
        // A qualified edge below overrides clear so no event is lost.
        sticky_d = sticky_q & ~clear;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (syn[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                cnt_d[i]   = '0;
                level_d[i] = syn[i];
                if ((syn[i] && mode[2*i]) || (!syn[i] && mode[2*i+1])) begin
                    edge_d[i]   = 1'b1;
                    sticky_d[i] = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt_q[i] <= '0;
            end
            level_q  <= '0;
            edge_q   <= '0;
            sticky_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            edge_q   <= edge_d;
            sticky_q <= sticky_d;
        end
    end

    assign edge_detect = edge_q;
    assign level       = level_q;
    assign sticky      = sticky_q;
    assign any_event   = |sticky_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Randomised and directed bench for multi_edge_detector with a queue-based scoreboard
// fed by a window-based reference model.
module tb_multi_edge_detector;

    localparam int unsigned CH = 4;
    localparam int unsigned SS = 2;
    localparam int unsigned FC = 3;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [CH-1:0]   data, clear, edge_detect, level, sticky;
    logic [2*CH-1:0] mode;
    logic            any_event;

    always #5 clock = ~clock;

    multi_edge_detector #(
        .CHANNELS     (CH),
        .SYNC_STAGES  (SS),
        .FILTER_CYCLES(FC)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .data       (data),
        .mode       (mode),
        .clear      (clear),
        .edge_detect(edge_detect),
        .level      (level),
        .sticky     (sticky),
        .any_event  (any_event)
    );

    typedef struct packed {
        logic [CH-1:0] edge_detect;
        logic [CH-1:0] level;
        logic [CH-1:0] sticky;
        logic          any_event;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: raw data reaches the filter SS cycles late; a channel's level
    // flips once the last FC filter samples all disagree with it.
    logic [CH-1:0] pipe[$];
    logic [CH-1:0] win[$];
    logic [CH-1:0] m_level, m_sticky;

    logic            rn_s;
    logic [CH-1:0]   d_s, c_s;
    logic [2*CH-1:0] m_s;

    task automatic model_reset();
        pipe = {};
        win  = {};
        repeat (SS) pipe.push_back('0);
        repeat (FC) win.push_back('0);
        m_level  = '0;
        m_sticky = '0;
    endtask

    task automatic step();
        exp_t          e;
        logic [CH-1:0] syn_cur;
        bit            all_differ;
        reset_n = rn_s;
        data    = d_s;
        mode    = m_s;
        clear   = c_s;
        e.edge_detect = '0;
        if (!rn_s) begin
            model_reset();
        end else begin
            syn_cur = pipe.pop_front();
            pipe.push_back(d_s);
            void'(win.pop_front());
            win.push_back(syn_cur);
            m_sticky = m_sticky & ~c_s;
            for (int i = 0; i < int'(CH); i++) begin
                all_differ = 1'b1;
                foreach (win[k]) if (win[k][i] == m_level[i]) all_differ = 1'b0;
                if (all_differ) begin
                    m_level[i] = ~m_level[i];
                    if ((m_level[i] && m_s[2*i]) || (!m_level[i] && m_s[2*i+1])) begin
                        e.edge_detect[i] = 1'b1;
                        m_sticky[i]      = 1'b1;
                    end
                end
            end
        end
        e.level     = m_level;
        e.sticky    = m_sticky;
        e.any_event = |m_sticky;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic tick(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    // Monitor: one expected entry per clock, compared mid-cycle.
    always @(negedge clock) begin
        exp_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{edge_detect, level, sticky, any_event};
            checks++;
            if (a === e) passes++;
            else $display("FAIL outputs t=%0t edge/level/sticky/any got %b/%b/%b/%b want %b/%b/%b/%b",
                          $time, a.edge_detect, a.level, a.sticky, a.any_event,
                          e.edge_detect, e.level, e.sticky, e.any_event);
        end
    end

    int ch2_pulses;

    initial begin
        model_reset();
        rn_s = 1'b0; d_s = 4'b0001; m_s = 8'h55; c_s = '0;
        // Input high through reset yields a rising edge after release.
        tick(3);
        rn_s = 1'b1;
        tick(8);
        // Channel 1 rising-only: pulse on rise, none on fall.
        d_s[1] = 1'b1; tick(10);
        d_s[1] = 1'b0; tick(8);
        // Channel 2 both edges, toggled every 8 cycles for 4 periods.
        m_s[5:4] = 2'b11;
        ch2_pulses = 0;
        for (int t = 0; t < 8; t++) begin
            d_s[2] = ~d_s[2];
            for (int j = 0; j < 8; j++) begin
                step();
                if (edge_detect[2]) ch2_pulses++;
            end
        end
        for (int j = 0; j < 8; j++) begin
            step();
            if (edge_detect[2]) ch2_pulses++;
        end
        checks++;
        if (ch2_pulses == 8) passes++;
        else $display("FAIL ch2_pulse_count got %0d want 8", ch2_pulses);
        // Channel 3: 2-cycle glitch, then a 3-cycle pulse.
        m_s[7:6] = 2'b11;
        d_s[3] = 1'b1; tick(2);
        d_s[3] = 1'b0; tick(5);
        d_s[3] = 1'b1; tick(3);
        d_s[3] = 1'b0; tick(8);
        // Clear coincident with a qualified falling edge on ch0, then clear-only.
        m_s[1:0] = 2'b11;
        d_s[0] = 1'b0; tick(4);
        c_s = 4'b0001; tick(1);
        c_s = 4'b1111; tick(1);
        c_s = '0; tick(4);
        // Reset while ch1's filter is part-way through a transition.
        d_s[1] = 1'b1; tick(4);
        rn_s = 1'b0; d_s[1] = 1'b0; tick(1);
        rn_s = 1'b1; tick(8);
        // Random phase.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < int'(CH); i++)
                if ($urandom_range(0, 5) == 0) d_s[i] = ~d_s[i];
            if ($urandom_range(0, 49) == 0) m_s = 8'($urandom);
            c_s  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            rn_s = ($urandom_range(0, 299) != 0);
            step();
        end
        @(negedge clock);
        @(negedge clock);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
